// File: rtl/mul_seq.sv
// Iterative XLEN x XLEN RISC-V multiplier (MUL/MULH/MULHSU/MULHU) that reuses one
// unsigned SUB x SUB multiplier over NCH*NCH passes and fixes the sign at the end.

module sub_mul #(
  parameter int SUB     = 32,
  parameter int USE_DSP = 0
) (
  input  logic [SUB-1:0]   a,
  input  logic [SUB-1:0]   b,
  output logic [2*SUB-1:0] p
);
  generate
    if (USE_DSP != 0) begin : g_dsp
      (* use_dsp = "yes" *) logic [2*SUB-1:0] p_dsp;
      assign p_dsp = {{SUB{1'b0}}, a} * {{SUB{1'b0}}, b};
      assign p = p_dsp;
    end else begin : g_fabric
      (* use_dsp = "no" *) logic [2*SUB-1:0] p_fab;
      assign p_fab = {{SUB{1'b0}}, a} * {{SUB{1'b0}}, b};
      assign p = p_fab;
    end
  endgenerate
endmodule

module mul_seq #(
  parameter int XLEN    = 64,
  parameter int SUB     = 32,
  parameter int USE_DSP = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res
);
  localparam int NCH = XLEN / SUB;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW  = $clog2(2 * XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state;
  logic [1:0]            op;
  logic [XLEN-1:0]       a_mag;
  logic [XLEN-1:0]       b_mag;
  logic                  neg;
  logic [2*XLEN-1:0]     acc;
  logic [CW-1:0]         i;
  logic [CW-1:0]         j;

  // MUL's low half is sign-agnostic, so only the high-half ops use signed operands.
  logic            a_signed;
  logic            b_signed;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;

  assign a_signed = (in_op == 2'b01) || (in_op == 2'b10);
  assign b_signed = (in_op == 2'b01);
  assign sign_a   = a_signed && in_a[XLEN-1];
  assign sign_b   = b_signed && in_b[XLEN-1];
  assign a_abs    = sign_a ? -in_a : in_a;
  assign b_abs    = sign_b ? -in_b : in_b;

  logic [SUB-1:0] a_chunk [NCH];
  logic [SUB-1:0] b_chunk [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chunk
      assign a_chunk[gi] = a_mag[gi*SUB +: SUB];
      assign b_chunk[gi] = b_mag[gi*SUB +: SUB];
    end
  endgenerate

  logic [2*SUB-1:0]  prod;
  logic [2*XLEN-1:0] prod_ext;
  logic [SW-1:0]     shamt;
  logic [2*XLEN-1:0] acc_sum;
  logic [2*XLEN-1:0] acc_fixed;

  sub_mul #(
    .SUB     (SUB),
    .USE_DSP (USE_DSP)
  ) u_sub_mul (
    .a (a_chunk[i]),
    .b (b_chunk[j]),
    .p (prod)
  );

  assign prod_ext  = (2*XLEN)'(prod);
  assign shamt     = (SW'(i) + SW'(j)) * SW'(SUB);
  assign acc_sum   = acc + (prod_ext << shamt);
  assign acc_fixed = neg ? -acc : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_res   <= '0;
      acc       <= '0;
      i         <= '0;
      j         <= '0;
      op        <= '0;
      a_mag     <= '0;
      b_mag     <= '0;
      neg       <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op       <= in_op;
            a_mag    <= a_abs;
            b_mag    <= b_abs;
            neg      <= sign_a ^ sign_b;
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          acc <= acc_sum;
          if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              i     <= '0;
              state <= FIX;
            end else begin
              i <= i + CW'(1);
            end
          end else begin
            j <= j + CW'(1);
          end
        end
        FIX: begin
          acc       <= acc_fixed;
          out_res   <= (op == 2'b00) ? acc_fixed[XLEN-1:0] : acc_fixed[2*XLEN-1:XLEN];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq.sv
// Directed and model-based checks of mul_seq with default parameters (XLEN=64, SUB=32).

module tb_mul_seq;
  localparam int XLEN = 64;
  localparam int NP   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_op = 2'b00;
  logic [XLEN-1:0] in_a = '0;
  logic [XLEN-1:0] in_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_res;

  int tests = 0;
  int fails = 0;

  mul_seq #(.XLEN(XLEN), .SUB(32), .USE_DSP(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
    logic [127:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{64{a[63]}}, a} : {64'b0, a};
    eb = (op == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  // Issue, wait for the result (bounded), check latency and value, then retire it.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input bit chk_lat);
    int lat;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (chk_lat) check({tag, "_latency"}, 64'(lat), 64'(NP + 1));
    check({tag, "_res"}, out_res, exp);
    $display("[TB] %s op=%0d a=%h b=%h res=%h lat=%0d", tag, op, a, b, out_res, lat + 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    logic [1:0]  rop;
    logic [63:0] ra, rb;

    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_res", out_res, 64'd0);

    // out_ready with nothing pending must be harmless
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_ready_noeffect", 64'(in_ready), 64'd1);

    run_op("mulhu_max", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    run_op("mul_neg", 2'b00, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
    run_op("mulh_neg", 2'b01, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op("mulh_minneg", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, 1'b1);
    run_op("mulhsu_neg", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op("mulh_zero", 2'b01, 64'd0, -64'sd9, 64'd0, 1'b1);
    run_op("mulhsu_minneg", 2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1'b1);

    // Backpressure, plus a competing issue while busy that must be ignored
    in_op = 2'b00; in_a = 64'd1234; in_b = 64'd1000; in_valid = 1'b1;
    tick();
    in_op = 2'b11; in_a = 64'd9; in_b = 64'd9;
    for (int k = 0; k < NP + 1; k++) tick();
    in_valid = 1'b0;
    check("stall_first_valid", 64'(out_valid), 64'd1);
    held = out_res;
    check("stall_first_res", held, 64'd1234000);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_res", out_res, held);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    $display("[TB] stall op=0 a=%h b=%h res=%h", 64'd1234, 64'd1000, out_res);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_release", 64'(in_ready), 64'd1);

    // Flush sampled at accept+3 aborts the op
    in_op = 2'b00; in_a = 64'd77; in_b = 64'd77; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 6; k++) tick();
    check("flush_no_result", 64'(out_valid), 64'd0);
    $display("[TB] flush op=0 a=%h b=%h aborted", 64'd77, 64'd77);

    // Flush together with an issue in IDLE: nothing accepted
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_not_accepted", 64'(in_ready), 64'd1);
    run_op("after_flush", 2'b00, 64'd5, 64'd6, 64'd30, 1'b1);

    // Reset mid-CALC
    in_op = 2'b11; in_a = 64'hDEAD_BEEF; in_b = 64'hCAFE; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_res", out_res, 64'd0);
    $display("[TB] reset mid-calc op=3 aborted");

    for (int n = 0; n < 2000; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = {$urandom(), $urandom()};
      rb  = {$urandom(), $urandom()};
      if (n % 7 == 0) ra = 64'h8000_0000_0000_0000;
      if (n % 11 == 0) rb = 64'hFFFF_FFFF_FFFF_FFFF;
      run_op("rand", rop, ra, rb, model(rop, ra, rb), (n % 50) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
